// File: rtl/timing_gen_if.sv
// timing_gen_if: control inputs and clock-enable strobes of timing_gen.
// master = controller side (drives EN/CLR/FAST); slave = timing_gen itself.
interface timing_gen_if;
   logic EN;
   logic CLR;
   logic FAST;
   logic CE_TICK;
   logic CE_MID;
   logic CE_SEC;
   logic BLINK;

   modport master (output EN, CLR, FAST, input CE_TICK, CE_MID, CE_SEC, BLINK);
   modport slave  (input EN, CLR, FAST, output CE_TICK, CE_MID, CE_SEC, BLINK);
endinterface

// File: rtl/timing_gen.sv
// timing_gen: cascaded clock-enable generator (base tick, mid tick, seconds
// tick) plus a 50% duty blink square wave. All outputs are registered strobes;
// no derived clocks.
// Optional feature macro: TIMING_GEN_BLINK_EN compiles in the BLINK logic;
// without it BLINK is tied low.
module timing_gen #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1000,
   parameter int DIV1    = 10,
   parameter int DIV2    = 100
) (
   input  logic        CLK,
   input  logic        RST,
   timing_gen_if.slave bus
);
   localparam int PRE = CLK_HZ / TICK_HZ;
   localparam int W0  = ($clog2(PRE)  < 1) ? 1 : $clog2(PRE);
   localparam int W1  = ($clog2(DIV1) < 1) ? 1 : $clog2(DIV1);
   localparam int W2  = ($clog2(DIV2) < 1) ? 1 : $clog2(DIV2);

   localparam logic [W0-1:0] C0_LAST = W0'(PRE - 1);
   localparam logic [W1-1:0] C1_LAST = W1'(DIV1 - 1);
   localparam logic [W2-1:0] C2_LAST = W2'(DIV2 - 1);
   // c2 value from which the next advance lands on the half-period point
   localparam logic [W2-1:0] C2_PREHALF = W2'(DIV2 / 2 - 1);

   // Parameter sanity, caught at elaboration
   if (CLK_HZ % TICK_HZ != 0) begin : g_chk_ratio
      $error("timing_gen: CLK_HZ must be a multiple of TICK_HZ");
   end
   if (PRE < 2) begin : g_chk_pre
      $error("timing_gen: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (DIV1 < 2) begin : g_chk_div1
      $error("timing_gen: DIV1 must be at least 2");
   end
   if (DIV2 < 2 || (DIV2 % 2) != 0) begin : g_chk_div2
      $error("timing_gen: DIV2 must be even and at least 2");
   end

   logic [W0-1:0] c0;
   logic [W1-1:0] c1;
   logic [W2-1:0] c2;
   logic          t0, t1, t2;

   assign t0 = (c0 == C0_LAST);
   assign t1 = t0 && (c1 == C1_LAST);
   assign t2 = t1 && (c2 == C2_LAST);

   // Cascaded counters; c2 is parked at 0 in fast-set mode so that leaving
   // fast mode restarts the seconds count cleanly.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c0 <= '0;
         c1 <= '0;
         c2 <= '0;
      end else if (bus.CLR) begin
         c0 <= '0;
         c1 <= '0;
         c2 <= '0;
      end else if (bus.EN) begin
         c0 <= t0 ? '0 : c0 + 1'b1;
         if (t0)
            c1 <= t1 ? '0 : c1 + 1'b1;
         if (bus.FAST)
            c2 <= '0;
         else if (t1)
            c2 <= t2 ? '0 : c2 + 1'b1;
      end
   end

   // Registered one-cycle strobes; pause or restart forces them low
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.CE_TICK <= 1'b0;
         bus.CE_MID  <= 1'b0;
         bus.CE_SEC  <= 1'b0;
      end else begin
         bus.CE_TICK <= bus.EN && !bus.CLR && t0;
         bus.CE_MID  <= bus.EN && !bus.CLR && t1;
         bus.CE_SEC  <= bus.EN && !bus.CLR && (bus.FAST ? t1 : t2);
      end
   end

`ifdef TIMING_GEN_BLINK_EN
   logic blink_q;

   // Blink: high for the first half of each seconds period; in fast-set mode
   // it simply toggles with every mid tick.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         blink_q <= 1'b1;
      end else if (bus.CLR) begin
         blink_q <= 1'b1;
      end else if (bus.EN && t1) begin
         if (bus.FAST)
            blink_q <= ~blink_q;
         else if (t2)
            blink_q <= 1'b1;
         else if (c2 == C2_PREHALF)
            blink_q <= 1'b0;
      end
   end

   assign bus.BLINK = blink_q;
`else
   assign bus.BLINK = 1'b0;
`endif
endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: directed scenarios plus a randomized run, every cycle checked
// against an arithmetic reference model of the strobe cadence.
module tb_timing_gen;
   localparam int CLK_HZ  = 20;
   localparam int TICK_HZ = 2;
   localparam int DIV1    = 3;
   localparam int DIV2    = 4;
   localparam int PRE     = CLK_HZ / TICK_HZ;
`ifdef TIMING_GEN_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;
   timing_gen_if bus();

   timing_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIV1(DIV1), .DIV2(DIV2))
      dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   int   checks = 0;
   int   failures = 0;
   int   edge_n = 0;
   logic en_r = 1'b1, clr_r = 1'b0, fast_r = 1'b0;

   // reference model: m = enabled edges since restart modulo one mid period,
   // s = mid ticks completed within the current seconds period
   int   m, s;
   logic mt, mm, ms, mb;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s edge=%0d observed=%0b expected=%0b", tag, edge_n, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m = 0; s = 0; mt = 0; mm = 0; ms = 0; mb = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_tick"},  bus.CE_TICK, mt);
      chk({tag, "_mid"},   bus.CE_MID,  mm);
      chk({tag, "_sec"},   bus.CE_SEC,  ms);
      chk({tag, "_blink"}, bus.BLINK,   BLINK_ON ? mb : 1'b0);
   endtask

   // async reset, checked while RST is high, released away from the clock edge
   task automatic do_reset();
      RST = 1'b1;
      #1;
      model_reset();
      check_outputs("reset");
      @(negedge CLK);
      RST = 1'b0;
      edge_n = 0;
   endtask

   // one clock edge with the current inputs, model advanced and compared
   task automatic step();
      logic tick, mid, sec;
      bus.EN = en_r; bus.CLR = clr_r; bus.FAST = fast_r;
      @(posedge CLK);
      #1;
      edge_n++;
      if (clr_r) begin
         model_reset();
      end else if (en_r) begin
         tick = ((m + 1) % PRE == 0);
         mid  = ((m + 1) % (PRE * DIV1) == 0);
         sec  = mid && (fast_r || s == DIV2 - 1);
         if (fast_r) begin
            s = 0;
            if (mid) mb = ~mb;
         end else if (mid) begin
            s = (s + 1) % DIV2;
            if (s == 0) mb = 1'b1;
            else if (s == DIV2 / 2) mb = 1'b0;
         end
         m = (m + 1) % (PRE * DIV1);
         mt = tick; mm = mid; ms = sec;
      end else begin
         mt = 0; mm = 0; ms = 0;
      end
      check_outputs("cyc");
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // bounded search for the next strobe: 0 tick, 1 mid, 2 sec; -1 on timeout
   task automatic wait_strobe(input int sel, input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         step();
         if ((sel == 0 && bus.CE_TICK) || (sel == 1 && bus.CE_MID) ||
             (sel == 2 && bus.CE_SEC)) begin
            at = edge_n;
            break;
         end
      end
   endtask

   int at;

   initial begin
      bus.EN = 1'b1; bus.CLR = 1'b0; bus.FAST = 1'b0;
      #2;
      // free run
      do_reset();
      wait_strobe(0, 20, at);   chki("free_first_tick", at, 10);
      wait_strobe(0, 20, at);   chki("free_second_tick", at, 20);
      wait_strobe(1, 40, at);   chki("free_first_mid", at, 30);
      wait_strobe(2, 150, at);  chki("free_first_sec", at, 120);
      chk("free_sec_has_mid", bus.CE_MID, 1'b1);
      chk("free_blink_sec1", bus.BLINK, BLINK_ON);
      wait_strobe(2, 150, at);  chki("free_second_sec", at, 240);
      run_n(60);

      // pause of 7 edges starting after edge 25
      do_reset();
      run_n(25);
      en_r = 1'b0;
      run_n(7);
      en_r = 1'b1;
      wait_strobe(0, 20, at);   chki("pause_next_tick", at, 37);

      // restart pulse at edge 55
      do_reset();
      run_n(54);
      clr_r = 1'b1;
      step();
      chk("clr_tick_low", bus.CE_TICK, 1'b0);
      chk("clr_blink_high", bus.BLINK, BLINK_ON);
      clr_r = 1'b0;
      wait_strobe(0, 20, at);   chki("clr_next_tick", at, 65);
      wait_strobe(1, 40, at);   chki("clr_next_mid", at, 85);

      // fast-set mode from reset
      fast_r = 1'b1;
      do_reset();
      wait_strobe(2, 40, at);   chki("fast_sec1", at, 30);
      chk("fast_blink1", bus.BLINK, 1'b0);
      wait_strobe(2, 40, at);   chki("fast_sec2", at, 60);
      chk("fast_blink2", bus.BLINK, BLINK_ON);
      wait_strobe(2, 40, at);   chki("fast_sec3", at, 90);
      fast_r = 1'b0;

      // blink square wave, then async reset in the middle of a count
      do_reset();
      run_n(59);
      chk("blink_edge59", bus.BLINK, BLINK_ON);
      step();
      chk("blink_edge60", bus.BLINK, 1'b0);
      do_reset();
      run_n(45);
      #2;
      do_reset();
      wait_strobe(0, 20, at);   chki("rst_mid_tick", at, 10);
      wait_strobe(1, 40, at);   chki("rst_mid_mid", at, 30);

      // randomized control traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en_r  = ($urandom_range(0, 9) != 0);
         clr_r = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 149) == 0) fast_r = ~fast_r;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/timing_gen.md
# timing_gen

Parametrised clock-enable generator for the digital clock datapath. It divides the system clock into three cascaded one-cycle enable strobes: a base tick, a mid-rate tick and a seconds tick. It also provides a 50% duty blink square wave for display colons and flashing digits. It has synchronous pause, restart and fast-set controls. Counter/display logic sits downstream and advances only on these strobes; no derived clocks are used.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, default 1000: base tick rate. `PRE = CLK_HZ/TICK_HZ`.
- `DIV1`, default 10: base ticks per mid tick (default 100 Hz).
- `DIV2`, default 100: mid ticks per seconds tick (default 1 Hz).
- `CLK` input, 1 bit: system clock, rising edge.
- `RST` input, 1 bit: reset, asynchronous, active-high.
- `EN` input, 1 bit: count enable. 0 pauses all stages.
- `CLR` input, 1 bit: synchronous restart of all stages.
- `FAST` input, 1 bit: fast-set mode. `CE_SEC` fires on every `CE_MID`.
- `CE_TICK` output, 1 bit: one-cycle strobe at `TICK_HZ`.
- `CE_MID` output, 1 bit: one-cycle strobe at `TICK_HZ/DIV1`.
- `CE_SEC` output, 1 bit: one-cycle strobe at `TICK_HZ/(DIV1*DIV2)`, or at the `CE_MID` rate when `FAST` is high.
- `BLINK` output, 1 bit: square wave, high during the first half of each seconds period.

## Operation
- There are three counters: `c0` counts 0..PRE-1, `c1` counts 0..DIV1-1, `c2` counts 0..DIV2-1.
- Each counter width is `$clog2` of its modulus, with a minimum of 1.
- Terminal flags: `t0 = (c0==PRE-1)`, `t1 = t0 && (c1==DIV1-1)`, `t2 = t1 && (c2==DIV2-1)`.
- On each edge with `EN=1` and `CLR=0`:
  - `c0` wraps to 0 at `PRE-1`, otherwise it increments.
  - `c1` advances, with wrap, only when `t0` is true.
  - `c2` advances, with wrap, only when `t1` is true and `FAST=0`.
- With `EN=0` all counters hold and every CE output is 0 on the next cycle. `BLINK` holds its value.
- `CLR=1` has priority over `EN`. It zeroes `c0`, `c1` and `c2`, drives all CE outputs to 0 and drives `BLINK` to 1, all on the next cycle. Counting resumes from 0 on the first edge with `CLR=0`.
- `FAST=1`:
  - `c2` is held at 0.
  - `CE_SEC` is registered from `t1` instead of `t2`.
  - `BLINK` toggles on every `CE_MID`.
  - Toggling `FAST` mid-period takes effect at the next edge. When `FAST` returns to 0, `c2` restarts from 0.
- Strobes are registered: `CE_TICK <= EN&&!CLR&&t0`. `CE_MID` and `CE_SEC` are formed the same way from `t1` and from `t2` (or `t1` in fast mode).
- `CE_MID` implies `CE_TICK` in the same cycle. `CE_SEC` implies `CE_MID` in the same cycle.
- Elaboration-time checks; a violation is a `$error`:
  - `CLK_HZ % TICK_HZ == 0`.
  - `PRE >= 2`.
  - `DIV1 >= 2`.
  - `DIV2 >= 2` and `DIV2` even.

## Timing
- Reset values: `c0=c1=c2=0`; `CE_TICK=CE_MID=CE_SEC=0`; `BLINK=1`.
- Cadence after `RST` release with `EN=1`:
  - The first `CE_TICK` is high in the cycle after rising edge number `PRE`, then every `PRE` cycles.
  - The first `CE_MID` appears after `PRE*DIV1` edges.
  - The first `CE_SEC` appears after `PRE*DIV1*DIV2` edges.
- Every strobe is exactly one cycle wide. `EN` and `CLR` have a latency of one cycle to the outputs.
- `BLINK` is registered and updates on the edge at which `c2` wraps to 0 or reaches `DIV2/2`. It is 1 while `c2 < DIV2/2`. Its period is exactly one seconds period.
- Pause does not lose phase: after `EN` returns to 1, the remaining count to the next strobe equals the count remaining when the pause began.
- Asserting `RST` mid-period clears everything immediately (asynchronous). Deassertion is synchronised externally.

## Configuration
- `TIMING_GEN_BLINK_EN`, when defined: the `BLINK` logic is compiled in as specified above.
- When not defined: `BLINK` is tied to constant 0 and no blink logic is synthesised. All other behaviour is unchanged.

## Test plan
Bench parameters for all scenarios: `CLK_HZ=20`, `TICK_HZ=2` (so `PRE=10`), `DIV1=3`, `DIV2=4`, `EN=1`, `CLR=0`, `FAST=0`.

- **Free run, 300 cycles** → `CE_TICK` after edges 10, 20, …; `CE_MID` after edges 30, 60, …; `CE_SEC` after edges 120 and 240, coincident with `CE_MID`/`CE_TICK`. All strobes are 1 cycle wide.
- **Pause:** `EN=0` for 7 cycles starting at edge 25 → the next `CE_TICK` arrives after edge 37 (not 30). No strobe is high while paused.
- **Restart:** `CLR` pulsed at edge 55, with `EN=1` held → outputs are 0 at edge 56. The next `CE_TICK` is 10 edges after `CLR` deasserts, and `CE_MID` is 30 edges after.
- **Fast mode:** `FAST=1` from reset → `CE_SEC` after edges 30, 60, 90. `BLINK` toggles at each of them.
- **Blink (macro defined):** `BLINK=1` for edges 0–59 and 0 for edges 60–119, repeating. With the macro undefined, `BLINK` is constant 0.
- **Reset mid-count:** `RST` asserted at edge 45 → `c0`, `c1`, `c2` and all outputs are cleared asynchronously. After release the cadence matches the free-run scenario from 0.
